// File: rtl/rf_enc_pkg.sv
// Shared types and helpers for the register-file write address encoder.
//   N          : number of registers / request lines
//   W          : binary register address width (log2 N)
//   reg_addr_t : binary register address
//   reg_mask_t : one bit per register
package rf_enc_pkg;

    localparam int unsigned N = 32;
    localparam int unsigned W = 5;

    typedef logic [W-1:0] reg_addr_t;
    typedef logic [N-1:0] reg_mask_t;

    // One-hot mask with only bit 'a' set.
    function automatic reg_mask_t onehot(input reg_addr_t a);
        return reg_mask_t'(1) << a;
    endfunction

endpackage : rf_enc_pkg

// File: rtl/rf_write_addr_encoder_rr_pick.sv
// Round-robin picker: finds the first set bit of 'mask', searching upward
// from index 'ptr' and wrapping from N-1 back to 0. Purely combinational.
// Ports:
//   mask  in  N  candidate bits
//   ptr   in  W  search start index
//   idx   out W  index of the selected bit (ptr when nothing is set)
//   found out 1  at least one bit of mask is set
module rr_pick
    import rf_enc_pkg::*;
(
    input  reg_mask_t mask,
    input  reg_addr_t ptr,
    output reg_addr_t idx,
    output logic      found
);

    reg_mask_t w_rot;
    reg_addr_t w_off;

    // Rotate so that bit ptr lands at position 0.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_rot[i] = mask[reg_addr_t'(ptr + reg_addr_t'(i))];
        end
    end

    // Fixed-priority encode: lowest set bit of the rotated mask wins.
    always_comb begin
        w_off = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = reg_addr_t'(i);
            end
        end
    end

    // Undo the rotation; N is a power of two so W-bit wrap is mod N.
    assign idx   = reg_addr_t'(ptr + w_off);
    assign found = |mask;

endmodule : rr_pick

// File: rtl/rf_write_addr_encoder.sv
// Register-file writeback address encoder: collects multi-hot write requests
// into a pending mask and issues one binary register address per cycle, in
// round-robin order, over a valid/ready handshake.
// Ports:
//   clk        in  1  system clock, rising edge
//   reset      in  1  asynchronous active-high reset
//   set_req    in  N  per-register request pulses
//   clear      in  1  synchronous flush of pending mask, slot and pointer
//   out_valid  out 1  out_addr holds a valid address
//   out_ready  in  1  consumer accepts out_addr this cycle
//   out_addr   out W  encoded register address
//   pending    out N  registered pending mask
//   busy       out 1  pending non-empty or slot occupied
module rf_write_addr_encoder
    import rf_enc_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  reg_mask_t set_req,
    input  logic      clear,
    output logic      out_valid,
    input  logic      out_ready,
    output reg_addr_t out_addr,
    output reg_mask_t pending,
    output logic      busy
);

    reg_mask_t r_pending;
    logic      r_out_valid;
    reg_addr_t r_out_addr;
    reg_addr_t r_ptr;

    reg_mask_t w_pending_nxt;
    logic      w_out_valid_nxt;
    reg_addr_t w_out_addr_nxt;
    reg_addr_t w_ptr_nxt;

    reg_addr_t w_idx;
    logic      w_found;
    logic      w_slot_free;
    logic      w_load;
    reg_mask_t w_load_mask;

    // Search only the registered mask; set_req never bypasses to the slot.
    rr_pick u_rr_pick (
        .mask  (r_pending),
        .ptr   (r_ptr),
        .idx   (w_idx),
        .found (w_found)
    );

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_load      = w_slot_free && w_found;
    assign w_load_mask = w_load ? onehot(w_idx) : '0;

    // Next-state logic for the pending mask, output slot and pointer.
    always_comb begin
        w_pending_nxt   = r_pending;
        w_out_valid_nxt = r_out_valid;
        w_out_addr_nxt  = r_out_addr;
        w_ptr_nxt       = r_ptr;

        if (clear) begin
            w_pending_nxt   = '0;
            w_out_valid_nxt = 1'b0;
            w_ptr_nxt       = '0;
        end else begin
            // OR-ing set_req after the load clear lets a same-cycle re-request survive.
            w_pending_nxt = (r_pending & ~w_load_mask) | set_req;
            if (w_slot_free) begin
                if (w_found) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_addr_nxt  = w_idx;
                    w_ptr_nxt       = reg_addr_t'(w_idx + reg_addr_t'(1));
                end else begin
                    w_out_valid_nxt = 1'b0;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_ptr       <= '0;
        end else begin
            r_pending   <= w_pending_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign pending   = r_pending;
    assign busy      = (|r_pending) || r_out_valid;

endmodule : rf_write_addr_encoder

// File: tb/tb_rf_write_addr_encoder.sv
// Directed self-checking bench for rf_write_addr_encoder.
module tb_rf_write_addr_encoder;

    logic        clk;
    logic        reset;
    logic [31:0] set_req;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] pending;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    rf_write_addr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .set_req   (set_req),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .pending   (pending),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic v, input logic [4:0] a);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        if (v) check({tag, "_addr"}, 32'(out_addr), 32'(a));
    endtask

    initial begin
        reset     = 1'b1;
        set_req   = '0;
        clear     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // 1. Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_addr", 32'(out_addr), 32'd0);
            check("idle_pending", pending, 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // 1b. Asynchronous reset while an address is held in the slot
        out_ready = 1'b0;
        set_req   = 32'h0000_00FF;
        tick();
        set_req = '0;
        tick();
        check_slot("pre_rst", 1'b1, 5'd0);
        check("pre_rst_pending", pending, 32'h0000_00FE);
        #3 reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_addr", 32'(out_addr), 32'd0);
        check("arst_pending", pending, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;

        // 2. Two requests, ptr=0 -> 0 then 2
        set_req = 32'h0000_0005;
        tick();
        set_req = '0;
        check("t2_pending", pending, 32'h0000_0005);
        check("t2_valid0", 32'(out_valid), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        tick();
        check_slot("t2_first", 1'b1, 5'd0);
        tick();
        check_slot("t2_second", 1'b1, 5'd2);
        check("t2_pending_empty", pending, 32'd0);
        tick();
        check_slot("t2_drain", 1'b0, 5'd0);
        check("t2_busy_end", 32'(busy), 32'd0);

        // 3. Backpressure: 4 held stable, then 5, 6 (ptr=3)
        out_ready = 1'b0;
        set_req   = 32'h0000_0070;
        tick();
        set_req = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_slot("t3_hold", 1'b1, 5'd4);
        end
        check("t3_pending", pending, 32'h0000_0060);
        out_ready = 1'b1;
        tick();
        check_slot("t3_next5", 1'b1, 5'd5);
        tick();
        check_slot("t3_next6", 1'b1, 5'd6);
        tick();
        check_slot("t3_drain", 1'b0, 5'd0);

        // 4. Wrap: issue 29 to move ptr to 30, then 31 before 0
        set_req = 32'h2000_0000;
        tick();
        set_req = '0;
        tick();
        check_slot("t4_29", 1'b1, 5'd29);
        tick();
        check_slot("t4_idle", 1'b0, 5'd0);
        set_req = 32'h8000_0001;
        tick();
        set_req = '0;
        tick();
        check_slot("t4_31", 1'b1, 5'd31);
        tick();
        check_slot("t4_0", 1'b1, 5'd0);
        tick();
        check_slot("t4_idle2", 1'b0, 5'd0);
        // ptr=1: 2 is reached before wrapping to 0
        set_req = 32'h0000_0005;
        tick();
        set_req = '0;
        tick();
        check_slot("t4_ptr1_a", 1'b1, 5'd2);
        tick();
        check_slot("t4_ptr1_b", 1'b1, 5'd0);
        tick();
        check_slot("t4_idle3", 1'b0, 5'd0);

        // 5a. Re-request on the load cycle issues address 3 twice (ptr=1)
        set_req = 32'h0000_0008;
        tick();
        check("t5_pending", pending, 32'h0000_0008);
        tick();
        set_req = '0;
        check_slot("t5_first3", 1'b1, 5'd3);
        check("t5_set_wins", pending, 32'h0000_0008);
        tick();
        check_slot("t5_second3", 1'b1, 5'd3);
        check("t5_pending_empty", pending, 32'd0);
        tick();
        check_slot("t5_idle", 1'b0, 5'd0);

        // 5b. Two pulses of bit 3 while pending merge into one issue (ptr=4)
        out_ready = 1'b0;
        set_req   = 32'h0000_0010;
        tick();
        set_req = '0;
        tick();
        check_slot("t5b_slot4", 1'b1, 5'd4);
        set_req = 32'h0000_0008;
        tick();
        tick();
        set_req = '0;
        tick();
        check("t5b_merged", pending, 32'h0000_0008);
        check_slot("t5b_hold4", 1'b1, 5'd4);
        out_ready = 1'b1;
        tick();
        check_slot("t5b_once3", 1'b1, 5'd3);
        tick();
        check_slot("t5b_idle", 1'b0, 5'd0);
        check("t5b_pending", pending, 32'd0);

        // 6. clear with a loaded slot drops same-cycle set_req and resets ptr
        out_ready = 1'b0;
        set_req   = 32'h0000_F0F0;
        tick();
        set_req = '0;
        tick();
        check_slot("t6_slot4", 1'b1, 5'd4);
        check("t6_pending", pending, 32'h0000_F0E0);
        clear   = 1'b1;
        set_req = 32'h0000_0001;
        tick();
        clear   = 1'b0;
        set_req = '0;
        check("t6_clr_pending", pending, 32'd0);
        check("t6_clr_valid", 32'(out_valid), 32'd0);
        check("t6_clr_busy", 32'(busy), 32'd0);
        // ptr=0 after clear: 0 issues before 31
        out_ready = 1'b1;
        set_req   = 32'h8000_0001;
        tick();
        set_req = '0;
        tick();
        check_slot("t6_ptr0_a", 1'b1, 5'd0);
        tick();
        check_slot("t6_ptr0_b", 1'b1, 5'd31);
        tick();
        check_slot("t6_idle", 1'b0, 5'd0);
        check("t6_busy_end", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rf_write_addr_encoder
